// File: rtl/bus_arb_6502_if.sv
// Bus bundle between the 6502 core, the DMA port and the single-port RAM.
interface bus_arb_6502_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) ();

  // core side
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_we;
  logic [DW-1:0] cpu_din;
  logic          cpu_rdy;

  // DMA side
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_we;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  // RAM side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_addr, cpu_dout, cpu_we,
    input  dma_req, dma_addr, dma_wdata, dma_we,
    input  mem_rdata,
    output cpu_din, cpu_rdy,
    output dma_ack, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we
  );

  // Environment view (core, DMA engine and RAM together)
  modport master (
    output cpu_addr, cpu_dout, cpu_we,
    output dma_req, dma_addr, dma_wdata, dma_we,
    output mem_rdata,
    input  cpu_din, cpu_rdy,
    input  dma_ack, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/bus_arb_6502.sv
// Cycle-stealing arbiter: DMA takes RAM cycles by dropping the core's RDY,
// with a burst limit that forces one CPU cycle after MAX_BURST grants.
module bus_arb_6502 #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  bus_arb_6502_if.slave   io_bus
);

  localparam int unsigned BW = 4;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);

  localparam logic [0:0] OWN_CPU = 1'b0;
  localparam logic [0:0] OWN_DMA = 1'b1;

  logic [0:0]    r_owner_q;
  logic [BW-1:0] r_burst_cnt;
  logic [DW-1:0] r_din_hold;
  logic          r_dma_rvalid;

  logic          w_dma_grant;
  logic [0:0]    w_owner_d;
  logic [BW-1:0] w_burst_d;
  logic [DW-1:0] w_din_hold_d;
  logic          w_dma_rvalid_d;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_mem_we;
  logic [DW-1:0] w_cpu_din;

  // Grant decision, RAM mux and next-state for owner/burst/hold/rvalid
  always_comb begin
    w_dma_grant    = 1'b0;
    w_mem_addr     = io_bus.cpu_addr;
    w_mem_wdata    = io_bus.cpu_dout;
    w_mem_we       = io_bus.cpu_we;
    w_cpu_din      = io_bus.mem_rdata;
    w_owner_d      = OWN_CPU;
    w_burst_d      = '0;
    w_din_hold_d   = r_din_hold;
    w_dma_rvalid_d = 1'b0;

    w_dma_grant = reset_n & io_bus.dma_req & (r_burst_cnt != BURST_LIM);

    if (w_dma_grant) begin
      w_mem_addr     = io_bus.dma_addr;
      w_mem_wdata    = io_bus.dma_wdata;
      w_mem_we       = io_bus.dma_we;
      w_owner_d      = OWN_DMA;
      w_burst_d      = r_burst_cnt + BW'(1);
      w_dma_rvalid_d = ~io_bus.dma_we;
    end

    // RAM data belongs to the core only if the core owned the previous cycle
    if (r_owner_q == OWN_CPU) begin
      w_din_hold_d = io_bus.mem_rdata;
    end else begin
      w_cpu_din = r_din_hold;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner_q    <= OWN_CPU;
      r_burst_cnt  <= '0;
      r_din_hold   <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_owner_q    <= w_owner_d;
      r_burst_cnt  <= w_burst_d;
      r_din_hold   <= w_din_hold_d;
      r_dma_rvalid <= w_dma_rvalid_d;
    end
  end

  assign io_bus.mem_addr   = w_mem_addr;
  assign io_bus.mem_wdata  = w_mem_wdata;
  assign io_bus.mem_we     = w_mem_we;
  assign io_bus.cpu_din    = w_cpu_din;
  assign io_bus.cpu_rdy    = ~w_dma_grant;
  assign io_bus.dma_ack    = w_dma_grant;
  assign io_bus.dma_rdata  = io_bus.mem_rdata;
  assign io_bus.dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_bus_arb_6502.sv
// Bench for bus_arb_6502: directed vector table, burst sequence and a
// randomized phase, all checked against a behavioural arbiter/RAM model.
module tb_bus_arb_6502;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXB = 4;

  logic clk;
  logic reset_n;

  bus_arb_6502_if #(.AW(AW), .DW(DW)) bus ();

  bus_arb_6502 #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM attached to the arbiter's memory port
  logic [7:0] ram [65536];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_chk;
  int n_fail;
  int cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory contents as the masters should see them, length of the current
  // DMA run, outstanding DMA read and the data the core is entitled to see.
  logic [7:0] shadow [65536];
  int         m_run;
  bit         m_rv_pend;
  logic [7:0] m_rv_data;
  logic [7:0] m_last_rd;    // what RAM returns this cycle
  bit         m_prev_cpu;   // previous cycle belonged to the core
  logic [7:0] m_core_seen;  // last data the core was shown

  bit         e_grant;
  logic [15:0] e_addr;
  logic [7:0] e_wd;
  bit         e_we;
  logic [7:0] e_din;

  task automatic check_model();
    e_grant = reset_n && bus.dma_req && (m_run < int'(MAXB));
    e_addr  = e_grant ? bus.dma_addr  : bus.cpu_addr;
    e_wd    = e_grant ? bus.dma_wdata : bus.cpu_dout;
    e_we    = e_grant ? bus.dma_we    : bus.cpu_we;
    e_din   = (!reset_n || m_prev_cpu) ? m_last_rd : m_core_seen;
    chk("dma_ack",   32'(bus.dma_ack),   32'(e_grant));
    chk("cpu_rdy",   32'(bus.cpu_rdy),   32'(!e_grant));
    chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    chk("cpu_din",   32'(bus.cpu_din),   32'(e_din));
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(reset_n && m_rv_pend));
    if (reset_n && m_rv_pend) chk("dma_rdata", 32'(bus.dma_rdata), 32'(m_rv_data));
  endtask

  task automatic update_model();
    m_last_rd   = shadow[e_addr];
    if (e_we) shadow[e_addr] = e_wd;
    m_core_seen = e_din;
    m_prev_cpu  = !e_grant;
    m_rv_pend   = e_grant && !bus.dma_we;
    m_rv_data   = m_last_rd;
    m_run       = e_grant ? m_run + 1 : 0;
  endtask

  task automatic drive(input logic rst, input logic req, input logic dwe,
                       input logic [15:0] daddr, input logic [7:0] dwd,
                       input logic [15:0] caddr, input logic cwe, input logic [7:0] cdout);
    reset_n       = rst;
    bus.dma_req   = req;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwd;
    bus.cpu_addr  = caddr;
    bus.cpu_we    = cwe;
    bus.cpu_dout  = cdout;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    update_model();
    #1;
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, req, dwe;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic [15:0] caddr;
    logic        cwe;
    logic [7:0]  cdout;
    logic        e_ack, e_rdy, e_rv;
    logic [7:0]  e_rdata;
    logic        din_chk;
    logic [7:0]  e_din;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t v(logic rst, logic req, logic dwe, logic [15:0] daddr,
                             logic [7:0] dwd, logic [15:0] caddr, logic cwe,
                             logic [7:0] cdout, logic ack, logic rdy, logic rv,
                             logic [7:0] rdata, logic dchk, logic [7:0] din);
    vec_t r;
    r.rst = rst; r.req = req; r.dwe = dwe; r.daddr = daddr; r.dwd = dwd;
    r.caddr = caddr; r.cwe = cwe; r.cdout = cdout;
    r.e_ack = ack; r.e_rdy = rdy; r.e_rv = rv; r.e_rdata = rdata;
    r.din_chk = dchk; r.e_din = din;
    return r;
  endfunction

  initial begin
    logic rq;
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int a = 0; a < 65536; a++) begin
      ram[a] = 8'h00;
      shadow[a] = 8'h00;
    end
    bus.mem_rdata = 8'h00;
    m_run = 0; m_rv_pend = 0; m_rv_data = 8'h00; m_last_rd = 8'h00;
    m_prev_cpu = 1; m_core_seen = 8'h00;
    drive(1'b0, 1'b1, 1'b1, 16'h0200, 8'h11, 16'h0000, 1'b0, 8'h00);

    //            rst req dwe daddr     dwd    caddr     cwe cdout  ack rdy rv rdata  dchk din
    // reset held with a pending request, then DMA write/read of 0x0200
    tbl[0]  = v(0, 1, 1, 16'h0200, 8'h11, 16'h0000, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[1]  = v(0, 1, 1, 16'h0200, 8'h11, 16'h0000, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[2]  = v(1, 1, 1, 16'h0200, 8'hA5, 16'h0000, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[3]  = v(1, 1, 0, 16'h0200, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[4]  = v(1, 0, 0, 16'h0200, 8'h00, 16'h0010, 1, 8'h3C, 0, 1, 1, 8'hA5, 0, 8'h00);
    // stall hold: core reads 0x3C, DMA writes/reads 0xFF, core must keep 0x3C
    tbl[5]  = v(1, 0, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[6]  = v(1, 1, 1, 16'h0300, 8'hFF, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h3C);
    tbl[7]  = v(1, 1, 0, 16'h0300, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 1, 8'h3C);
    tbl[8]  = v(1, 1, 0, 16'h0300, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hFF, 1, 8'h3C);
    tbl[9]  = v(1, 1, 0, 16'h0300, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hFF, 1, 8'h3C);
    tbl[10] = v(1, 1, 0, 16'h0300, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 1, 8'hFF, 1, 8'h3C);
    tbl[11] = v(1, 0, 0, 16'h0300, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 0, 8'h00, 1, 8'h3C);
    // request gap: 2 high, 1 low, 4 high -> no forced CPU cycle
    tbl[12] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[13] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[14] = v(1, 0, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 1, 8'hA5, 0, 8'h00);
    tbl[15] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[16] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[17] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[18] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[19] = v(1, 0, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 1, 8'hA5, 0, 8'h00);
    // reset during the 2nd read of a burst, then a full fresh burst
    tbl[20] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[21] = v(0, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
    tbl[22] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
    tbl[23] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[24] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[25] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 8'h00);
    tbl[26] = v(1, 1, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 1, 8'hA5, 0, 8'h00);
    tbl[27] = v(1, 0, 0, 16'h0200, 8'h00, 16'h0010, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00);

    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd,
            tbl[i].caddr, tbl[i].cwe, tbl[i].cdout);
      @(negedge clk);
      check_model();
      chk("tbl_ack",    32'(bus.dma_ack),    32'(tbl[i].e_ack));
      chk("tbl_rdy",    32'(bus.cpu_rdy),    32'(tbl[i].e_rdy));
      chk("tbl_rvalid", 32'(bus.dma_rvalid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk("tbl_rdata", 32'(bus.dma_rdata), 32'(tbl[i].e_rdata));
      if (tbl[i].din_chk) chk("tbl_cpu_din", 32'(bus.cpu_din), 32'(tbl[i].e_din));
      if (!tbl[i].rst) chk("tbl_reset_mux", 32'(bus.mem_addr), 32'(tbl[i].caddr));
      finish_cycle();
    end

    // continuous request for 20 cycles: 1111 0 repeating
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0200, 8'h00, 16'h0010, 1'b0, 8'h00);
      @(negedge clk);
      check_model();
      chk("burst_ack", 32'(bus.dma_ack), 32'((i % 5) != 4));
      chk("burst_rdy", 32'(bus.cpu_rdy), 32'((i % 5) == 4));
      finish_cycle();
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rq = ($urandom_range(0, 9) < 7);
      drive(($urandom_range(0, 49) != 0), rq, logic'($urandom_range(0, 1)),
            16'h0040 + 16'($urandom_range(0, 7)), 8'($urandom),
            16'h0040 + 16'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            8'($urandom));
      @(negedge clk);
      check_model();
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb_6502.md
# bus_arb_6502

Single-port memory arbiter sitting between the 6502 core and the SoC RAM, adding a second bus master (DMA port) without modifying the CPU. Arbitration is cycle-by-cycle: DMA cycles are stolen by deasserting the core's RDY, with a burst limit that guarantees CPU progress. Read data returned to each master is steered and held so a stalled CPU sees stable DI.

## Interface
- AW, 16, address width
- DW, 8, data width
- MAX_BURST, 4, max consecutive DMA grants before one forced CPU cycle (1..15)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  AW  core address, valid every cycle
- cpu_dout  in  DW  core write data
- cpu_we  in  1  core write enable
- cpu_din  out  DW  read data to core DI
- cpu_rdy  out  1  core RDY; 0 = core stalled this cycle
- dma_req  in  1  DMA access request, held until acked
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_we  in  1  DMA write enable
- dma_ack  out  1  DMA access granted this cycle
- dma_rdata  out  DW  DMA read data
- dma_rvalid  out  1  dma_rdata valid (one-cycle pulse)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DW  RAM read data, one cycle after address (synchronous RAM)

## Operation
- Registers: owner_q (last cycle's owner, CPU/DMA), burst_cnt (4 bits), din_hold (DW), dma_rvalid.
- Grant (combinational): dma_grant = reset_n & dma_req & (burst_cnt != MAX_BURST); otherwise CPU owns the cycle.
- dma_grant=1: mem_addr/mem_wdata/mem_we = dma_addr/dma_wdata/dma_we; dma_ack=1; cpu_rdy=0.
- dma_grant=0: mem_* = cpu_addr/cpu_dout/cpu_we; dma_ack=0; cpu_rdy=1.
- burst_cnt: +1 on dma_grant; cleared on any CPU-owned cycle (including the forced one at MAX_BURST) and whenever dma_req=0.
- owner_q <= DMA if dma_grant else CPU.
- cpu_din = mem_rdata when owner_q=CPU, else din_hold; din_hold <= mem_rdata on every cycle with owner_q=CPU. Core always sees the last CPU read result during stalls.
- dma_rvalid <= dma_grant & ~dma_we; dma_rdata = mem_rdata when dma_rvalid=1, don't-care otherwise.
- DMA writes produce no dma_rvalid.

## Timing
- Reset (reset_n=0, async): owner_q=CPU, burst_cnt=0, din_hold=0, dma_rvalid=0; outputs cpu_rdy=1, dma_ack=0, cpu_din=mem_rdata, mem_* follow CPU. Reset mid-burst drops the DMA grant immediately; the in-flight read produces no dma_rvalid.
- CPU path: zero added latency; mem_* is a pure mux of cpu_* when CPU owns.
- DMA: ack in the same cycle as the granted request; write committed at that edge; read data with dma_rvalid exactly one cycle after ack.
- Continuous dma_req: pattern is MAX_BURST acks, 1 CPU cycle, repeat; CPU gets ≥1 of every MAX_BURST+1 cycles.
- dma_req deasserted for one cycle: burst_cnt resets; next request starts a fresh burst.
- Back-to-back DMA reads: dma_rvalid high on consecutive cycles, one per ack.
- CPU write coincident with DMA grant: CPU write suppressed (cpu_rdy=0, core re-presents it next cycle).

## Test plan
- Reset: hold reset_n=0 with dma_req=1 -> dma_ack=0, cpu_rdy=1, mem_addr=cpu_addr, dma_rvalid=0; release -> dma_ack=1 next cycle.
- DMA write then read: DMA writes 0xA5 to 0x0200, then reads 0x0200 -> ack each cycle, dma_rvalid one cycle after read ack with dma_rdata=0xA5, CPU stalled 2 cycles.
- Burst limit: dma_req held 20 cycles, MAX_BURST=4 -> ack pattern 1111 0 1111 0 ..., cpu_rdy exactly its complement.
- Stall hold: CPU reads 0x3C from 0x0010, then DMA steals 3 cycles reading 0xFF data -> cpu_din stays 0x3C throughout stall.
- Request gap: dma_req high 2 cycles, low 1, high 4 -> 6 acks total with no forced CPU cycle inside either run.
- Reset mid-burst: assert reset_n=0 during 2nd DMA read -> dma_ack drops immediately, no dma_rvalid, burst_cnt=0 after release.
